// File: rtl/fifo_access_ctrl.sv
// Round-robin write arbiter plus write/read interleaver for a single-port-op FIFO.
// Tracks occupancy locally and returns read data one cycle after issue with a valid strobe.
module fifo_access_ctrl #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 32,
    parameter int CW    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               rd_req,
    output logic               rd_ready,
    output logic               rd_valid,
    output logic [DW-1:0]      rd_data,
    output logic [CW-1:0]      level,
    output logic               fifo_wr_en,
    output logic               fifo_rd_en,
    output logic [DW-1:0]      fifo_data_in,
    input  logic [DW-1:0]      fifo_data_op,
    input  logic               fifo_full,
    input  logic               fifo_empty
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    typedef enum logic {TURN_WR, TURN_RD} turn_t;

    turn_t         turn;
    logic [CW-1:0] level_q;
    logic [PW-1:0] rr_ptr;
    logic          rd_valid_q;

    logic          can_wr, can_rd, wr_pend, rd_pend, do_wr, do_rd;
    logic [PW-1:0] grant_idx;
    logic          grant_found;
    int unsigned   idx;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
    end

    assign can_wr  = (level_q < DEPTH_L) && !fifo_full;
    assign can_rd  = (level_q != '0) && !fifo_empty;
    assign wr_pend = can_wr && grant_found;
    assign rd_pend = can_rd && rd_req;

    // The turn only breaks ties; a lone pending op always goes.
    assign do_wr = !rst && wr_pend && (!rd_pend || turn == TURN_WR);
    assign do_rd = !rst && rd_pend && (!wr_pend || turn == TURN_RD);

    assign req_ready    = do_wr ? (NREQ'(1) << grant_idx) : '0;
    assign fifo_wr_en   = do_wr;
    assign fifo_data_in = do_wr ? req_data[int'(grant_idx)*DW +: DW] : '0;
    assign rd_ready     = do_rd;
    assign fifo_rd_en   = do_rd;
    assign level        = level_q;
    assign rd_data      = fifo_data_op;

    // Masked by rst so a read issued just before reset never reports valid.
    assign rd_valid     = rd_valid_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q    <= '0;
            rr_ptr     <= '0;
            turn       <= TURN_WR;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= do_rd;
            if (do_wr) begin
                level_q <= level_q + 1'b1;
                rr_ptr  <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                turn    <= TURN_RD;
            end else if (do_rd) begin
                level_q <= level_q - 1'b1;
                turn    <= TURN_WR;
            end
        end
    end

endmodule

// File: doc/fifo_access_ctrl.md
Name: fifo_access_ctrl

Overview:
Sequencer and arbiter sitting in front of the 32-entry, 8-bit single-port-op FIFO. Shares the FIFO write port between NREQ producers using round-robin. Interleaves write and read operations fairly, because the FIFO ignores any cycle with both wr_en and rd_en high. Tracks occupancy independently and delivers read data with a valid strobe.

Parameters:
NREQ, 4, number of write requesters
DW, 8, data width; must match FIFO
DEPTH, 32, FIFO capacity in entries
CW, 6, occupancy counter width, clog2(DEPTH)+1

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high; shares rst with the FIFO
req_valid  in  NREQ  per-requester write request
req_data  in  NREQ*DW  requester i data at bits [i*DW +: DW]
req_ready  out  NREQ  one-hot; write accepted this cycle when valid&ready
rd_req  in  1  consumer read request (level)
rd_ready  out  1  read accepted this cycle when rd_req&rd_ready
rd_valid  out  1  read data valid, one cycle after acceptance
rd_data  out  DW  read data, qualified by rd_valid
level  out  CW  current occupancy 0..DEPTH
fifo_wr_en  out  1  to FIFO wr_en
fifo_rd_en  out  1  to FIFO rd_en
fifo_data_in  out  DW  to FIFO data_in
fifo_data_op  in  DW  from FIFO data_op
fifo_full  in  1  from FIFO full
fifo_empty  in  1  from FIFO empty

Behaviour:
- Reset while rst=1: level=0, rr_ptr=0, turn=WR, rd_valid=0.
- Reset while rst=1: req_ready, rd_ready, fifo_wr_en and fifo_rd_en are forced to 0 combinationally.
- Reset mid-operation: a read accepted in the cycle before rst does not produce rd_valid. Any in-flight request is dropped; the FIFO is reset by the same rst.
- can_wr = (level < DEPTH) && !fifo_full. can_rd = (level != 0) && !fifo_empty.
- wr_pend = can_wr && |req_valid. rd_pend = can_rd && rd_req.
- Per cycle, exactly one of three outcomes: write issued, read issued, or idle. fifo_wr_en and fifo_rd_en are never high together.
- Fairness state turn ∈ {WR, RD}:
  - Both wr_pend and rd_pend: issue the op named by turn, then toggle turn.
  - Only one pending: issue it, and set turn to the other op.
  - Neither pending: turn holds.
- Write grant: round-robin search starting at rr_ptr, choosing the first i with req_valid[i].
  - req_ready[i]=1, fifo_wr_en=1, fifo_data_in=req_data[i], all combinational in the same cycle.
  - On issue, rr_ptr <= (i+1) mod NREQ.
  - fifo_data_in = 0 when no write is issued.
- Read issue: rd_ready=1 and fifo_rd_en=1 combinationally.
  - rd_valid=1 on the next cycle, with rd_data = fifo_data_op (the FIFO registers its output on the issue edge).
  - rd_valid is a one-cycle pulse per accepted read; back-to-back reads give consecutive pulses.
- level: +1 on an issued write, -1 on an issued read, registered. It never exceeds DEPTH and never underflows.
- Full boundary: at level=DEPTH or fifo_full=1, all req_ready stay 0 and requests wait. No data loss; the requester holds valid.
- Empty boundary: at level=0 or fifo_empty=1, rd_ready=0 and rd_req waits.
- Requesters may drop req_valid without a grant; no state is retained for them.
- rr_ptr advances only on an issued write.

Test Plan:
- Reset, then req_valid=4'b0001 with data 0x11..0x14 over four cycles, then rd_req held. Required: level 1,2,3,4; rd_valid pulses with 0x11,0x12,0x13,0x14; level returns to 0.
- req_valid=4'b1111 held, no reads. Required: grants 0,1,2,3,0,... one per cycle; level increments each cycle.
- Continue the previous test until level=32. Required: req_ready=0 and fifo_wr_en=0 from then on; level stays 32; no FIFO write is attempted.
- level=5, req_valid=4'b0010 and rd_req held together, turn=WR. Required: ops alternate W,R,W,R; level oscillates 6,5,6,5; fifo_wr_en and fifo_rd_en are never both high.
- rd_req=1 at level=0. Required: rd_ready=0 and rd_valid stays 0. After one write of 0xA5: read is issued next cycle, then rd_valid=1 with rd_data=0xA5.
- Read issued, rst asserted on the following cycle. Required: rd_valid=0, level=0, all strobes 0. After release, the first write is granted to requester 0.
